// File: rtl/qspi_bus_share_pkg.sv
// Shared definitions for the QSPI bus-sharing arbiter: line count and FSM states.
package qspi_bus_share_pkg;

    localparam int QSPI_LINES = 4;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        DRAIN = 2'd1,
        GUARD = 2'd2
    } state_t;

endpackage

// File: rtl/qspi_bus_share.sv
// Time-shares one quad-SPI SRAM between NUM_CH masters, handing over only
// when the current owner's chip select is high, with an idle guard between owners.
module qspi_bus_share
    import qspi_bus_share_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int GUARD_CYCLES = 2,
    localparam int SEL_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SEL_W-1:0]             req_sel,
    input  logic [NUM_CH-1:0]            ch_cs_n,
    input  logic [NUM_CH-1:0]            ch_sck,
    input  logic [NUM_CH-1:0]            ch_sio_oe,
    input  logic [QSPI_LINES*NUM_CH-1:0] ch_sio_o,
    output logic [QSPI_LINES*NUM_CH-1:0] ch_sio_i,
    output logic                         dev_cs_n,
    output logic                         dev_sck,
    output logic                         dev_sio_oe,
    output logic [QSPI_LINES-1:0]        dev_sio_o,
    input  logic [QSPI_LINES-1:0]        dev_sio_i,
    output logic [NUM_CH-1:0]            ch_grant,
    output logic                         switching,
    output logic [NUM_CH-1:0]            ch_conflict
);

    localparam int GCW = $clog2(GUARD_CYCLES + 1);
    localparam logic [SEL_W:0] NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

    state_t              r_state;
    logic [SEL_W-1:0]    r_owner;
    logic [SEL_W-1:0]    r_target;
    logic [GCW-1:0]      r_guard_cnt;
    logic [NUM_CH-1:0]   r_conflict;

    logic                  w_req_valid;
    logic                  w_routed;
    logic                  w_own_cs_n;
    logic                  w_own_sck;
    logic                  w_own_oe;
    logic [QSPI_LINES-1:0] w_own_sio;
    logic [NUM_CH-1:0]     w_is_owner;
    logic [NUM_CH-1:0]     w_conflict_set;

    assign w_req_valid = ({1'b0, req_sel} < NUM_CH_EXT);

    // Reset and GUARD both disconnect every channel from the device
    assign w_routed = !reset && (r_state != GUARD);

    always_comb begin
        w_own_cs_n = 1'b1;
        w_own_sck  = 1'b0;
        w_own_oe   = 1'b0;
        w_own_sio  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_owner == SEL_W'(k)) begin
                w_own_cs_n = ch_cs_n[k];
                w_own_sck  = ch_sck[k];
                w_own_oe   = ch_sio_oe[k];
                w_own_sio  = ch_sio_o[k*QSPI_LINES +: QSPI_LINES];
            end
        end
    end

    assign dev_cs_n   = w_routed ? w_own_cs_n : 1'b1;
    assign dev_sck    = w_routed ? w_own_sck  : 1'b0;
    assign dev_sio_oe = w_routed ? w_own_oe   : 1'b0;
    assign dev_sio_o  = w_routed ? w_own_sio  : '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign w_is_owner[g]     = w_routed && (r_owner == SEL_W'(g));
        assign w_conflict_set[g] = !ch_cs_n[g] && !w_is_owner[g];
        assign ch_sio_i[g*QSPI_LINES +: QSPI_LINES] = w_is_owner[g] ? dev_sio_i : '0;
    end

    assign ch_grant    = w_is_owner;
    assign switching   = !reset && ((r_state == DRAIN) || (r_state == GUARD));
    assign ch_conflict = r_conflict;

    // A req_sel equal to the owner while draining cancels the handover without a guard
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HOLD;
            r_owner     <= '0;
            r_target    <= '0;
            r_guard_cnt <= '0;
            r_conflict  <= '0;
        end else begin
            r_conflict <= r_conflict | w_conflict_set;
            case (r_state)
                HOLD: begin
                    if (w_req_valid && (req_sel != r_owner)) begin
                        r_target <= req_sel;
                        r_state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_req_valid) begin
                        r_target <= req_sel;
                    end
                    if (w_req_valid && (req_sel == r_owner)) begin
                        r_state <= HOLD;
                    end else if (w_own_cs_n) begin
                        r_state     <= GUARD;
                        r_guard_cnt <= GCW'(GUARD_CYCLES - 1);
                    end
                end
                GUARD: begin
                    if (r_guard_cnt == '0) begin
                        r_owner <= r_target;
                        r_state <= HOLD;
                    end else begin
                        r_guard_cnt <= r_guard_cnt - GCW'(1);
                    end
                end
                default: r_state <= HOLD;
            endcase
        end
    end

endmodule
